// File: rtl/useq.sv
`default_nettype none
// ============================================================================
// Module      : useq
// Description : Parametrised microcode sequencer. Computes the next
//               micro-address from the sequencing fields of the instruction
//               at upc, the condition flags, a return-address stack and a
//               loop counter, and drives a synchronous microcode ROM.
//               Adds a HALT state, stall handling and sticky error reporting.
//
// Ports       : clk, rst      - clock / synchronous active-high reset
//               stall         - hold the current address and freeze all state
//               op            - sequencing op of the instruction at upc
//               target        - branch / call / loop target
//               offset        - dispatch offset
//               cond_sel      - which cond bit BRZ / BRNZ test
//               cond          - condition flags from the datapath
//               cnt_load      - value loaded by LDCNT
//               next_upc      - combinational ROM address
//               upc           - address of the instruction on the ROM output
//               sp            - return-stack occupancy, 0..DEPTH
//               cnt           - loop counter
//               halted        - sequencer is in the HALT state
//               err, err_code - sticky first error (01 ovf, 10 unf, 11 ill)
//
// Revision    : 1.0 - initial release
// ============================================================================
module useq #(
    parameter int AW    = 10,
    parameter int DEPTH = 4,
    parameter int CW    = 8,
    parameter int NCOND = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       stall,
    input  logic [3:0]                 op,
    input  logic [AW-1:0]              target,
    input  logic [AW-1:0]              offset,
    input  logic [$clog2(NCOND)-1:0]   cond_sel,
    input  logic [NCOND-1:0]           cond,
    input  logic [CW-1:0]              cnt_load,
    output logic [AW-1:0]              next_upc,
    output logic [AW-1:0]              upc,
    output logic [$clog2(DEPTH+1)-1:0] sp,
    output logic [CW-1:0]              cnt,
    output logic                       halted,
    output logic                       err,
    output logic [1:0]                 err_code
);

    localparam int SPW = $clog2(DEPTH + 1);

    localparam logic [3:0] c_OP_NEXT     = 4'd0;
    localparam logic [3:0] c_OP_JUMP     = 4'd1;
    localparam logic [3:0] c_OP_BRZ      = 4'd2;
    localparam logic [3:0] c_OP_BRNZ     = 4'd3;
    localparam logic [3:0] c_OP_CALL     = 4'd4;
    localparam logic [3:0] c_OP_RET      = 4'd5;
    localparam logic [3:0] c_OP_DISPATCH = 4'd6;
    localparam logic [3:0] c_OP_LDCNT    = 4'd7;
    localparam logic [3:0] c_OP_LOOP     = 4'd8;
    localparam logic [3:0] c_OP_HALT     = 4'd9;

    localparam logic [1:0] c_ERR_OVF = 2'b01;
    localparam logic [1:0] c_ERR_UNF = 2'b10;
    localparam logic [1:0] c_ERR_ILL = 2'b11;

    localparam logic [0:0] c_ST_RUN  = 1'b0;
    localparam logic [0:0] c_ST_HALT = 1'b1;

    logic [0:0]     r_state;
    logic [AW-1:0]  r_upc;
    logic [SPW-1:0] r_sp;
    logic [CW-1:0]  r_cnt;
    logic           r_err;
    logic [1:0]     r_err_code;
    logic [AW-1:0]  r_stack [DEPTH];

    logic [0:0]     w_state_nxt;
    logic [AW-1:0]  w_upc_nxt;
    logic [AW-1:0]  w_upc_inc;
    logic [AW-1:0]  w_top;
    logic [SPW-1:0] w_sp_nxt;
    logic [CW-1:0]  w_cnt_nxt;
    logic           w_push;
    logic           w_err_ev;
    logic [1:0]     w_err_code_ev;
    logic           w_cond_bit;

    assign w_upc_inc  = r_upc + AW'(1);
    assign w_cond_bit = cond[cond_sel];

    // Top-of-stack read: entry sp-1 when the stack is non-empty.
    always_comb begin
        w_top = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (SPW'(i + 1) == r_sp) begin
                w_top = r_stack[i];
            end
        end
    end

    // Next-state / next-address decode. Stalled or halted cycles keep every
    // default, so a stalled op only takes effect on the first unstalled cycle.
    always_comb begin
        w_state_nxt   = r_state;
        w_upc_nxt     = r_upc;
        w_sp_nxt      = r_sp;
        w_cnt_nxt     = r_cnt;
        w_push        = 1'b0;
        w_err_ev      = 1'b0;
        w_err_code_ev = 2'b00;

        if (rst) begin
            w_upc_nxt = '0;
        end else if (r_state == c_ST_RUN && !stall) begin
            case (op)
                c_OP_NEXT: w_upc_nxt = w_upc_inc;
                c_OP_JUMP: w_upc_nxt = target;
                c_OP_BRZ:  w_upc_nxt = w_cond_bit ? w_upc_inc : target;
                c_OP_BRNZ: w_upc_nxt = w_cond_bit ? target : w_upc_inc;
                c_OP_CALL: begin
                    if (r_sp == SPW'(DEPTH)) begin
                        w_upc_nxt     = w_upc_inc;
                        w_err_ev      = 1'b1;
                        w_err_code_ev = c_ERR_OVF;
                    end else begin
                        w_upc_nxt = target;
                        w_push    = 1'b1;
                        w_sp_nxt  = r_sp + SPW'(1);
                    end
                end
                c_OP_RET: begin
                    if (r_sp == '0) begin
                        w_upc_nxt     = w_upc_inc;
                        w_err_ev      = 1'b1;
                        w_err_code_ev = c_ERR_UNF;
                    end else begin
                        w_upc_nxt = w_top;
                        w_sp_nxt  = r_sp - SPW'(1);
                    end
                end
                c_OP_DISPATCH: w_upc_nxt = w_upc_inc + offset;
                c_OP_LDCNT: begin
                    w_upc_nxt = w_upc_inc;
                    w_cnt_nxt = cnt_load;
                end
                c_OP_LOOP: begin
                    if (r_cnt != '0) begin
                        w_upc_nxt = target;
                        w_cnt_nxt = r_cnt - CW'(1);
                    end else begin
                        w_upc_nxt = w_upc_inc;
                    end
                end
                c_OP_HALT: begin
                    w_upc_nxt   = r_upc;
                    w_state_nxt = c_ST_HALT;
                end
                default: begin
                    w_upc_nxt     = w_upc_inc;
                    w_err_ev      = 1'b1;
                    w_err_code_ev = c_ERR_ILL;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_RUN;
            r_upc      <= '0;
            r_sp       <= '0;
            r_cnt      <= '0;
            r_err      <= 1'b0;
            r_err_code <= 2'b00;
        end else begin
            r_state <= w_state_nxt;
            r_upc   <= w_upc_nxt;
            r_sp    <= w_sp_nxt;
            r_cnt   <= w_cnt_nxt;
            // Only the first error is recorded.
            if (w_err_ev && !r_err) begin
                r_err      <= 1'b1;
                r_err_code <= w_err_code_ev;
            end
        end
    end

    // Stack storage needs no reset: entries at or above sp are don't-care.
    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (SPW'(i) == r_sp) begin
                    r_stack[i] <= w_upc_inc;
                end
            end
        end
    end

    assign next_upc = w_upc_nxt;
    assign upc      = r_upc;
    assign sp       = r_sp;
    assign cnt      = r_cnt;
    assign halted   = (r_state == c_ST_HALT);
    assign err      = r_err;
    assign err_code = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_useq.sv
`default_nettype none
// ============================================================================
// Module      : tb_useq
// Description : Directed self-checking bench for the useq microcode
//               sequencer (AW=10, DEPTH=4, CW=8, NCOND=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_useq;

    localparam int AW    = 10;
    localparam int DEPTH = 4;
    localparam int CW    = 8;
    localparam int NCOND = 4;

    localparam logic [3:0] c_NEXT = 4'd0, c_JUMP = 4'd1, c_BRZ = 4'd2,
                           c_BRNZ = 4'd3, c_CALL = 4'd4, c_RET = 4'd5,
                           c_DISP = 4'd6, c_LDCNT = 4'd7, c_LOOP = 4'd8,
                           c_HALT = 4'd9;

    logic                       clk;
    logic                       rst;
    logic                       stall;
    logic [3:0]                 op;
    logic [AW-1:0]              target;
    logic [AW-1:0]              offset;
    logic [$clog2(NCOND)-1:0]   cond_sel;
    logic [NCOND-1:0]           cond;
    logic [CW-1:0]              cnt_load;
    logic [AW-1:0]              next_upc;
    logic [AW-1:0]              upc;
    logic [$clog2(DEPTH+1)-1:0] sp;
    logic [CW-1:0]              cnt;
    logic                       halted;
    logic                       err;
    logic [1:0]                 err_code;

    int n_checks = 0;
    int n_fail   = 0;

    useq #(.AW(AW), .DEPTH(DEPTH), .CW(CW), .NCOND(NCOND)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .stall    (stall),
        .op       (op),
        .target   (target),
        .offset   (offset),
        .cond_sel (cond_sel),
        .cond     (cond),
        .cnt_load (cnt_load),
        .next_upc (next_upc),
        .upc      (upc),
        .sp       (sp),
        .cnt      (cnt),
        .halted   (halted),
        .err      (err),
        .err_code (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are settled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an instruction and let combinational outputs settle.
    task automatic drive(input logic [3:0] o, input logic [AW-1:0] t, input logic [AW-1:0] f);
        op     = o;
        target = t;
        offset = f;
        #1;
    endtask

    int body_cnt;
    int guard;

    initial begin
        rst = 1'b1; stall = 1'b0; op = c_NEXT; target = '0; offset = '0;
        cond_sel = '0; cond = '0; cnt_load = '0;

        // ---------------- reset state ----------------
        tick(); tick();
        chk("rst_next_upc", 32'(next_upc), 32'd0);
        chk("rst_upc",      32'(upc),      32'd0);
        chk("rst_sp",       32'(sp),       32'd0);
        chk("rst_cnt",      32'(cnt),      32'd0);
        chk("rst_halted",   32'(halted),   32'd0);
        chk("rst_err",      32'(err),      32'd0);
        chk("rst_err_code", 32'(err_code), 32'd0);
        rst = 1'b0;
        #1;

        // ---------------- NEXT x3 ----------------
        for (int i = 0; i < 3; i++) begin
            drive(c_NEXT, '0, '0);
            chk("next_comb", 32'(next_upc), 32'(i + 1));
            tick();
            chk("next_upc", 32'(upc), 32'(i + 1));
        end

        // ---------------- mid-run reset ----------------
        drive(c_CALL, 10'd100, '0); tick();
        chk("pre_rst_sp", 32'(sp), 32'd1);
        drive(4'd13, '0, '0); tick();
        chk("pre_rst_err", 32'(err), 32'd1);
        rst = 1'b1; #1;
        chk("rst_mid_next_upc", 32'(next_upc), 32'd0);
        tick(); tick();
        rst = 1'b0; #1;
        chk("rst_mid_upc", 32'(upc), 32'd0);
        chk("rst_mid_sp",  32'(sp),  32'd0);
        chk("rst_mid_err", 32'(err), 32'd0);

        // ---------------- CALL x4, overflow, RET x4, underflow ----------------
        drive(c_JUMP, 10'd5, '0); tick();
        chk("jump_upc", 32'(upc), 32'd5);
        drive(c_CALL, 10'd20, '0); tick();
        drive(c_CALL, 10'd40, '0); tick();
        drive(c_CALL, 10'd60, '0); tick();
        drive(c_CALL, 10'd80, '0); tick();
        chk("call4_upc", 32'(upc), 32'd80);
        chk("call4_sp",  32'(sp),  32'd4);
        drive(c_CALL, 10'd200, '0);
        chk("ovf_next_upc", 32'(next_upc), 32'd81);
        tick();
        chk("ovf_sp",       32'(sp),       32'd4);
        chk("ovf_err",      32'(err),      32'd1);
        chk("ovf_err_code", 32'(err_code), 32'd1);
        drive(c_RET, '0, '0); tick();
        chk("ret1", 32'(upc), 32'd61);
        drive(c_RET, '0, '0); tick();
        chk("ret2", 32'(upc), 32'd41);
        drive(c_RET, '0, '0); tick();
        chk("ret3", 32'(upc), 32'd21);
        drive(c_RET, '0, '0); tick();
        chk("ret4",    32'(upc), 32'd6);
        chk("ret4_sp", 32'(sp),  32'd0);
        drive(c_RET, '0, '0);
        chk("unf_after_ovf_next", 32'(next_upc), 32'd7);
        tick();
        chk("unf_keeps_code", 32'(err_code), 32'd1);

        // ---------------- fresh reset, underflow then illegal ----------------
        rst = 1'b1; tick(); rst = 1'b0; #1;
        drive(c_RET, '0, '0);
        chk("unf_next_upc", 32'(next_upc), 32'd1);
        tick();
        chk("unf_err_code", 32'(err_code), 32'd2);
        drive(4'd12, '0, '0);
        chk("ill_next_upc", 32'(next_upc), 32'd2);
        tick();
        chk("ill_keeps_code", 32'(err_code), 32'd2);

        // ---------------- LDCNT 3 + LOOP (body at 3, LOOP at 4) ----------------
        cnt_load = 8'd3;
        drive(c_LDCNT, '0, '0); tick();
        chk("ldcnt_cnt", 32'(cnt), 32'd3);
        body_cnt = 0;
        guard    = 0;
        while (upc != 10'd5 && guard < 20) begin
            if (upc == 10'd3) begin
                body_cnt++;
                drive(c_NEXT, '0, '0);
            end else begin
                drive(c_LOOP, 10'd3, '0);
            end
            tick();
            guard++;
        end
        chk("loop_body_count", 32'(body_cnt), 32'd4);
        chk("loop_cnt_end",    32'(cnt),      32'd0);
        chk("loop_fallthru",   32'(upc),      32'd5);

        // ---------------- BRZ / BRNZ ----------------
        cond = 4'b0100; cond_sel = 2'd2;
        drive(c_BRZ, 10'd50, '0);
        chk("brz_not_taken", 32'(next_upc), 32'd6);
        tick();
        drive(c_BRNZ, 10'd50, '0);
        chk("brnz_taken", 32'(next_upc), 32'd50);
        tick();
        cond_sel = 2'd1;
        drive(c_BRZ, 10'd300, '0);
        chk("brz_taken", 32'(next_upc), 32'd300);

        // ---------------- DISPATCH wrap ----------------
        drive(c_JUMP, 10'd1022, '0); tick();
        drive(c_DISP, '0, 10'd7);
        chk("disp_wrap", 32'(next_upc), 32'd6);
        tick();
        chk("disp_upc", 32'(upc), 32'd6);

        // ---------------- stall on CALL ----------------
        stall = 1'b1;
        drive(c_CALL, 10'd300, '0);
        for (int i = 0; i < 5; i++) begin
            chk("stall_next_upc", 32'(next_upc), 32'd6);
            tick();
            chk("stall_upc", 32'(upc), 32'd6);
            chk("stall_sp",  32'(sp),  32'd0);
        end
        stall = 1'b0; #1;
        chk("unstall_next_upc", 32'(next_upc), 32'd300);
        tick();
        chk("unstall_upc", 32'(upc), 32'd300);
        chk("unstall_sp",  32'(sp),  32'd1);
        drive(c_RET, '0, '0); tick();
        chk("unstall_ret", 32'(upc), 32'd7);

        // ---------------- HALT ----------------
        drive(c_HALT, '0, '0);
        chk("halt_next_upc", 32'(next_upc), 32'd7);
        tick();
        chk("halt_flag", 32'(halted), 32'd1);
        for (int i = 0; i < 6; i++) begin
            stall = i[0];
            drive(c_JUMP, 10'd99, '0);
            chk("halt_next_frozen", 32'(next_upc), 32'd7);
            tick();
            chk("halt_upc_frozen", 32'(upc), 32'd7);
        end
        stall = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0; #1;
        chk("halt_rst_upc",    32'(upc),    32'd0);
        chk("halt_rst_halted", 32'(halted), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
